// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner select for a shared 4:1 mux, grant held until released.
// Define ARB_TIMEOUT_EN to revoke grants held longer than MAX_HOLD cycles.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [1:0] S,
    output logic [3:0] GNT,
    output logic       VALID,
    output logic       TIMEOUT
);
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [1:0]       last, last_nx, s_nx, pick, idx;
    logic [3:0]       gnt_nx;
    logic             valid_nx, timeout_nx, found, release_req, expire;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // Search starts just after the last owner, so it ends up lowest priority.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign release_req = DONE || !REQ[S];
    assign expire      = TO_EN && (cnt == HOLD_LIM);

    always_comb begin
        state_nx   = state;
        last_nx    = last;
        s_nx       = S;
        gnt_nx     = GNT;
        valid_nx   = VALID;
        timeout_nx = 1'b0;
        cnt_nx     = cnt;
        if (state == IDLE) begin
            if (found) begin
                state_nx = BUSY;
                s_nx     = pick;
                gnt_nx   = 4'b0001 << pick;
                valid_nx = 1'b1;
                last_nx  = pick;
                cnt_nx   = '0;
            end
        end else if (release_req || expire) begin
            state_nx   = IDLE;
            gnt_nx     = 4'b0000;
            valid_nx   = 1'b0;
            timeout_nx = !release_req;
        end else begin
            cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            last    <= 2'd3;
            S       <= 2'd0;
            GNT     <= 4'b0000;
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            S       <= s_nx;
            GNT     <= gnt_nx;
            VALID   <= valid_nx;
            TIMEOUT <= timeout_nx;
            cnt     <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for mux4_rr_arbiter (MAX_HOLD=4).
module tb_mux4_rr_arbiter;
    logic       CLK, RST, DONE, VALID, TIMEOUT;
    logic [3:0] REQ, GNT;
    logic [1:0] S;

    typedef struct {
        string      name;
        logic [1:0] s;
        logic [3:0] g;
        logic       v;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event smp;

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
        .S(S), .GNT(GNT), .VALID(VALID), .TIMEOUT(TIMEOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: every sample event consumes one expectation from the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(smp);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL underflow: output sampled with no expectation queued");
            end else begin
                e = q.pop_front();
                if ({S, GNT, VALID, TIMEOUT} !== {e.s, e.g, e.v, e.t}) begin
                    bad++;
                    $display("FAIL %s: got S=%0d GNT=%b VALID=%b TIMEOUT=%b, want S=%0d GNT=%b VALID=%b TIMEOUT=%b",
                             e.name, S, GNT, VALID, TIMEOUT, e.s, e.g, e.v, e.t);
                end
            end
        end
    end

    task automatic expect_out(input string nm, input logic [1:0] es, input logic [3:0] eg,
                              input logic ev, input logic et);
        exp_t e;
        e.name = nm; e.s = es; e.g = eg; e.v = ev; e.t = et;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic d, input string nm,
                        input logic [1:0] es, input logic [3:0] eg, input logic ev, input logic et);
        REQ  = r;
        DONE = d;
        expect_out(nm, es, eg, ev, et);
        @(posedge CLK);
        #1 ->smp;
    endtask

    // Pulses RST between edges and samples while it is high, before any edge.
    task automatic areset(input string nm);
        #2 RST = 1'b1;
        expect_out(nm, 2'd0, 4'b0000, 1'b0, 1'b0);
        #1 ->smp;
        #2 RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; REQ = 4'b0000; DONE = 1'b0;
        #12;
        expect_out("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
        ->smp;
        #1 RST = 1'b0;

        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle", 2'd0, 4'b0000, 1'b0, 1'b0);

        step(4'b0100, 1'b0, "req2_grant", 2'd2, 4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b0, "req2_hold1", 2'd2, 4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b0, "req2_hold2", 2'd2, 4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, "req2_done",  2'd2, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, "req2_idle",  2'd2, 4'b0000, 1'b0, 1'b0);

        areset("reset_before_rr");
        step(4'b1111, 1'b0, "rr_g0",   2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b1111, 1'b1, "rr_gap0", 2'd0, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, "rr_g1",   2'd1, 4'b0010, 1'b1, 1'b0);
        step(4'b1111, 1'b1, "rr_gap1", 2'd1, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b1, "rr_g2_done_in_idle", 2'd2, 4'b0100, 1'b1, 1'b0);
        step(4'b1111, 1'b1, "rr_gap2", 2'd2, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, "rr_g3",   2'd3, 4'b1000, 1'b1, 1'b0);
        step(4'b1111, 1'b1, "rr_gap3", 2'd3, 4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, "rr_g0_again", 2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, "rr_end",  2'd0, 4'b0000, 1'b0, 1'b0);

        step(4'b0010, 1'b0, "own1_grant",   2'd1, 4'b0010, 1'b1, 1'b0);
        step(4'b1010, 1'b0, "own1_no_preempt", 2'd1, 4'b0010, 1'b1, 1'b0);
        step(4'b1000, 1'b0, "own1_drop",    2'd1, 4'b0000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, "own3_grant",   2'd3, 4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, "own3_release", 2'd3, 4'b0000, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, "to_hold", 2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b0, "to_revoke",  2'd0, 4'b0000, 1'b0, 1'b1);
        step(4'b0001, 1'b0, "to_regrant", 2'd0, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, "to_hold2", 2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, "to_done_at_limit", 2'd0, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, "to_idle", 2'd0, 4'b0000, 1'b0, 1'b0);
`else
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, "hold_no_limit", 2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, "hold_release", 2'd0, 4'b0000, 1'b0, 1'b0);
`endif

        step(4'b0100, 1'b0, "pre_rst_grant2", 2'd2, 4'b0100, 1'b1, 1'b0);
        areset("async_reset_midgrant");
        step(4'b0101, 1'b0, "post_rst_g0",   2'd0, 4'b0001, 1'b1, 1'b0);
        step(4'b0101, 1'b1, "post_rst_gap",  2'd0, 4'b0000, 1'b0, 1'b0);
        step(4'b0101, 1'b0, "post_rst_g2",   2'd2, 4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b0, "post_rst_idle", 2'd2, 4'b0000, 1'b0, 1'b0);

        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
